// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The "slave" modport is the loader itself: it consumes the byte stream and
// drives the memory write port. The "master" modport is the opposite side:
// the byte source together with the instruction memory that observes writes.
interface imem_loader_if #(
   parameter int ADDR_W = 8
);

   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              imem_wr_enb;
   logic [ADDR_W-1:0] imem_wr_addr;
   logic [31:0]       imem_wr_data;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  imem_wr_enb,
      input  imem_wr_addr,
      input  imem_wr_data
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output imem_wr_enb,
      output imem_wr_addr,
      output imem_wr_data
   );

endinterface

// File: rtl/imem_loader.sv
// Boot-time program loader placed in front of the instruction memory.
// It takes a framed byte stream (16-bit word count, 4*N payload bytes sent
// MSB first, XOR checksum byte), writes big-endian 32-bit words to word
// addresses 0..N-1, and raises cpu_run once the checksum matches. The CPU
// clock enable hangs off cpu_run, so the core sits idle while loading.
module imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              reload,
   imem_loader_if.slave      bus,
   output logic              cpu_run,
   output logic              load_err,
   output logic [ADDR_W:0]   words_loaded
);

   typedef enum logic [2:0] {
      HDR_HI,
      HDR_LO,
      DATA,
      CSUM,
      DONE,
      ERR
   } state_t;

   state_t            state_q;
   logic [15:0]       cnt_q;
   logic [1:0]        byteIdx_q;
   logic [ADDR_W:0]   wordCnt_q;
   logic [23:0]       asm_q;
   logic [7:0]        acc_q;
   logic              wrEnb_q;
   logic [ADDR_W-1:0] wrAddr_q;
   logic [31:0]       wrData_q;
   logic              cpuRun_q;
   logic              loadErr_q;

   logic              inReady;
   logic              accept;
   logic [31:0]       wordNext;
   logic [15:0]       countFull;
   logic              oversize;
   logic              lastWord;

   // Ready only in the byte-consuming states; a reload cycle never takes a byte.
   assign inReady = ((state_q == HDR_HI) || (state_q == HDR_LO) ||
                     (state_q == DATA)   || (state_q == CSUM)) && !reload;
   assign accept  = bus.in_valid && inReady;

   // The incoming byte completes the word below the three already assembled.
   assign wordNext  = {asm_q, bus.in_data};
   assign countFull = {cnt_q[15:8], bus.in_data};

   // A count above the memory depth would wrap the address, so it is refused.
   assign oversize = {1'b0, countFull} > (17'd1 << ADDR_W);

   // The word finishing now is word N-1 when the written count will reach N.
   assign lastWord = (17'(wordCnt_q) + 17'd1) == {1'b0, cnt_q};

   assign bus.in_ready     = inReady;
   assign bus.imem_wr_enb  = wrEnb_q;
   assign bus.imem_wr_addr = wrAddr_q;
   assign bus.imem_wr_data = wrData_q;
   assign cpu_run          = cpuRun_q;
   assign load_err         = loadErr_q;
   assign words_loaded     = wordCnt_q;

   // Frame parser: header, payload assembly, checksum and the sticky end states.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= HDR_HI;
         cnt_q     <= '0;
         byteIdx_q <= '0;
         wordCnt_q <= '0;
         asm_q     <= '0;
         acc_q     <= '0;
         wrEnb_q   <= 1'b0;
         wrAddr_q  <= '0;
         wrData_q  <= '0;
         cpuRun_q  <= 1'b0;
         loadErr_q <= 1'b0;
      end else begin
         wrEnb_q <= 1'b0;
         if (reload) begin
            state_q   <= HDR_HI;
            cnt_q     <= '0;
            byteIdx_q <= '0;
            wordCnt_q <= '0;
            asm_q     <= '0;
            acc_q     <= '0;
            cpuRun_q  <= 1'b0;
            loadErr_q <= 1'b0;
         end else if (accept) begin
            case (state_q)
               HDR_HI: begin
                  cnt_q[15:8] <= bus.in_data;
                  acc_q       <= acc_q ^ bus.in_data;
                  state_q     <= HDR_LO;
               end
               HDR_LO: begin
                  cnt_q[7:0] <= bus.in_data;
                  acc_q      <= acc_q ^ bus.in_data;
                  if (oversize) begin
                     state_q   <= ERR;
                     loadErr_q <= 1'b1;
                  end else if (countFull == 16'd0) begin
                     state_q <= CSUM;
                  end else begin
                     state_q <= DATA;
                  end
               end
               DATA: begin
                  acc_q     <= acc_q ^ bus.in_data;
                  asm_q     <= wordNext[23:0];
                  byteIdx_q <= byteIdx_q + 2'd1;
                  if (byteIdx_q == 2'd3) begin
                     wrEnb_q   <= 1'b1;
                     wrAddr_q  <= wordCnt_q[ADDR_W-1:0];
                     wrData_q  <= wordNext;
                     wordCnt_q <= wordCnt_q + 1'b1;
                     if (lastWord) begin
                        state_q <= CSUM;
                     end
                  end
               end
               CSUM: begin
                  if (bus.in_data == acc_q) begin
                     state_q  <= DONE;
                     cpuRun_q <= 1'b1;
                  end else begin
                     state_q   <= ERR;
                     loadErr_q <= 1'b1;
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader. Frames are built as byte queues and a
// reference model derives the expected writes and final status directly from
// the frame format; a monitor records every write strobe the loader makes.
module tb_imem_loader;

   localparam int ADDR_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk;
   logic              rst_n;
   logic              reload;
   logic              cpu_run;
   logic              load_err;
   logic [ADDR_W:0]   words_loaded;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .reload       (reload),
      .bus          (bus),
      .cpu_run      (cpu_run),
      .load_err     (load_err),
      .words_loaded (words_loaded)
   );

   int total = 0;
   int bad   = 0;

   logic [7:0]  frameQ[$];
   logic [31:0] obsAddr[$];
   logic [31:0] obsData[$];

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Record each write strobe; the written-word count must already include it.
   always @(negedge clk) begin
      if (bus.imem_wr_enb === 1'b1) begin
         obsAddr.push_back(32'(bus.imem_wr_addr));
         obsData.push_back(bus.imem_wr_data);
         checkOutput("wl_at_strobe", 32'(words_loaded), 32'(bus.imem_wr_addr) + 32'd1);
      end
   end

   // Append the XOR of every byte so far, optionally corrupted.
   task automatic appendCsum(input bit corrupt);
      logic [7:0] x;
      x = 8'h00;
      foreach (frameQ[i]) x ^= frameQ[i];
      if (corrupt) x ^= 8'($urandom_range(1, 255));
      frameQ.push_back(x);
   endtask

   // Random frame of n words.
   task automatic buildFrame(input int n, input bit corrupt);
      frameQ.delete();
      frameQ.push_back(8'(n >> 8));
      frameQ.push_back(8'(n));
      for (int i = 0; i < 4 * n; i++) frameQ.push_back(8'($urandom));
      appendCsum(corrupt);
   endtask

   // Drive nBytes of frameQ; mode 0 = valid always, 1 = toggling, 2 = random gaps.
   task automatic applyStimulus(input int nBytes, input int mode);
      int  idx;
      int  cyc;
      bit  ph;
      bit  v;
      bit  acc;
      idx = 0;
      cyc = 0;
      ph  = 1'b1;
      while (idx < nBytes && cyc < 20 * nBytes + 100) begin
         case (mode)
            0:       v = 1'b1;
            1:       v = ph;
            default: v = ($urandom_range(0, 2) != 0);
         endcase
         ph = !ph;
         bus.in_valid = v;
         bus.in_data  = v ? frameQ[idx] : 8'($urandom);
         @(negedge clk);
         acc = bus.in_valid && bus.in_ready;
         @(posedge clk);
         #1;
         if (acc) idx++;
         cyc++;
      end
      bus.in_valid = 1'b0;
      if (idx < nBytes) checkOutput("send_timeout", 32'(idx), 32'(nBytes));
   endtask

   // Send frameQ and compare the loader's behaviour with the frame-level model.
   task automatic runFrame(input string name, input int mode);
      int         n;
      int         consumed;
      int         expWrites;
      int         expWl;
      bit         expRun;
      bit         expErr;
      logic [7:0] x;
      obsAddr.delete();
      obsData.delete();
      n = {frameQ[0], frameQ[1]};
      if (n > DEPTH) begin
         consumed  = 2;
         expWrites = 0;
         expWl     = 0;
         expRun    = 1'b0;
         expErr    = 1'b1;
      end else begin
         consumed  = 3 + 4 * n;
         expWrites = n;
         expWl     = n;
         x = 8'h00;
         for (int i = 0; i < 2 + 4 * n; i++) x ^= frameQ[i];
         expRun = (frameQ[2 + 4 * n] == x);
         expErr = !expRun;
      end
      applyStimulus(consumed, mode);
      @(negedge clk);
      checkOutput({name, "_cpu_run"}, 32'(cpu_run), 32'(expRun));
      checkOutput({name, "_load_err"}, 32'(load_err), 32'(expErr));
      checkOutput({name, "_words_loaded"}, 32'(words_loaded), 32'(expWl));
      checkOutput({name, "_in_ready_end"}, 32'(bus.in_ready), 32'd0);
      // Further bytes must be ignored once the frame has ended.
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      repeat (3) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      checkOutput({name, "_in_ready_hold"}, 32'(bus.in_ready), 32'd0);
      checkOutput({name, "_cpu_run_hold"}, 32'(cpu_run), 32'(expRun));
      checkOutput({name, "_load_err_hold"}, 32'(load_err), 32'(expErr));
      checkOutput({name, "_nwrites"}, 32'(obsAddr.size()), 32'(expWrites));
      for (int i = 0; i < expWrites && i < obsAddr.size(); i++) begin
         checkOutput({name, "_addr"}, obsAddr[i], 32'(i));
         checkOutput({name, "_data"}, obsData[i],
                     {frameQ[2 + 4 * i], frameQ[3 + 4 * i],
                      frameQ[4 + 4 * i], frameQ[5 + 4 * i]});
      end
      @(posedge clk);
      #1;
   endtask

   // One-cycle reload with a byte offered; the byte must not be taken.
   task automatic pulseReload();
      reload       = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      @(negedge clk);
      checkOutput("reload_in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
      #1;
      reload       = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      checkOutput("reload_cpu_run", 32'(cpu_run), 32'd0);
      checkOutput("reload_load_err", 32'(load_err), 32'd0);
      checkOutput("reload_words", 32'(words_loaded), 32'd0);
      checkOutput("reload_in_ready_after", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic singleWordFrame();
      frameQ = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2C};
   endtask

   // Main sequence of directed and randomized frames.
   initial begin
      rst_n        = 1'b0;
      reload       = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      @(negedge clk);
      checkOutput("rst_cpu_run", 32'(cpu_run), 32'd0);
      checkOutput("rst_load_err", 32'(load_err), 32'd0);
      checkOutput("rst_words", 32'(words_loaded), 32'd0);
      checkOutput("rst_wr_enb", 32'(bus.imem_wr_enb), 32'd0);
      checkOutput("rst_wr_addr", 32'(bus.imem_wr_addr), 32'd0);
      checkOutput("rst_wr_data", bus.imem_wr_data, 32'd0);
      checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single word, then check the literal word value too.
      singleWordFrame();
      runFrame("single", 0);
      if (obsData.size() > 0) checkOutput("single_word_literal", obsData[0], 32'h20080005);
      pulseReload();

      // Two words with in_valid toggling every cycle.
      frameQ = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      appendCsum(1'b0);
      runFrame("toggle", 1);
      if (obsData.size() > 1) checkOutput("toggle_word1_literal", obsData[1], 32'hAABBCCDD);
      pulseReload();

      // Bad checksum.
      frameQ = '{8'h00, 8'h01, 8'h20, 8'h08, 8'h00, 8'h05, 8'h2D};
      runFrame("badcsum", 0);
      pulseReload();

      // Oversize count and the largest legal count.
      frameQ = '{8'h01, 8'h01};
      runFrame("oversize", 0);
      pulseReload();
      buildFrame(DEPTH, 1'b0);
      runFrame("fulldepth", 0);
      pulseReload();

      // Empty frame.
      frameQ = '{8'h00, 8'h00, 8'h00};
      runFrame("empty", 0);
      pulseReload();

      // Reload after five payload bytes, then a clean frame.
      buildFrame(2, 1'b0);
      applyStimulus(7, 0);
      pulseReload();
      singleWordFrame();
      runFrame("after_reload", 0);
      pulseReload();

      // Reset after five payload bytes, then a clean frame.
      buildFrame(2, 1'b0);
      applyStimulus(7, 0);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midrst_cpu_run", 32'(cpu_run), 32'd0);
      checkOutput("midrst_words", 32'(words_loaded), 32'd0);
      checkOutput("midrst_wr_enb", 32'(bus.imem_wr_enb), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      singleWordFrame();
      runFrame("after_reset", 0);
      pulseReload();

      // Randomized frames, some with corrupted checksums or oversize counts.
      for (int k = 0; k < 12; k++) begin
         if (k == 5) begin
            frameQ.delete();
            frameQ.push_back(8'($urandom_range(2, 255)));
            frameQ.push_back(8'($urandom));
         end else begin
            buildFrame($urandom_range(0, 6), ($urandom_range(0, 3) == 0));
         end
         runFrame("random", $urandom_range(0, 2));
         pulseReload();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
